alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/seq_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcodes, ALU selects, FSM states and instruction field layout
//               shared by the ALU sequencer and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int C_DATA_W   = 8;
  localparam int C_IDX_W    = 3;

  localparam int C_OP_LSB   = 24;
  localparam int C_DEST_LSB = 16;
  localparam int C_SRC1_LSB = 8;
  localparam int C_SRC2_LSB = 0;

  localparam logic [7:0] C_OP_LOADI = 8'h00;
  localparam logic [7:0] C_OP_MOV   = 8'h01;
  localparam logic [7:0] C_OP_ADD   = 8'h02;
  localparam logic [7:0] C_OP_AND   = 8'h03;
  localparam logic [7:0] C_OP_OR    = 8'h04;
  localparam logic [7:0] C_OP_SUB   = 8'h05;

  localparam logic [2:0] C_SEL_FWD = 3'b000;
  localparam logic [2:0] C_SEL_ADD = 3'b001;
  localparam logic [2:0] C_SEL_AND = 3'b010;
  localparam logic [2:0] C_SEL_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPRD = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op <= C_OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : seq_regfile
// Description : 8x8 register file, two asynchronous read ports, one
//               synchronous write port, asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [C_IDX_W-1:0]  i_raddr1,
  output logic [C_DATA_W-1:0] o_rdata1,
  input  logic [C_IDX_W-1:0]  i_raddr2,
  output logic [C_DATA_W-1:0] o_rdata2,
  input  logic                i_we,
  input  logic [C_IDX_W-1:0]  i_waddr,
  input  logic [C_DATA_W-1:0] i_wdata
);

  logic [7:0][C_DATA_W-1:0] r_mem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Four-state instruction sequencer driving an external ALU.
//               Define SEQ_STATUS_FLAGS_EN to add zero/negative flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  output logic [7:0]  o_alu_data1,
  output logic [7:0]  o_alu_data2,
  output logic [2:0]  o_alu_select,
  input  logic [7:0]  i_alu_result,
  output logic        o_result_valid,
  output logic [2:0]  o_result_dest,
  output logic [7:0]  o_result_data,
  output logic        o_illegal_op
`ifdef SEQ_STATUS_FLAGS_EN
  ,
  output logic        o_zero_flag,
  output logic        o_neg_flag
`endif
);

  state_t      r_state;
  logic [7:0]  r_op;
  logic [2:0]  r_dest;
  logic [2:0]  r_src1;
  logic [7:0]  r_src2;
  logic [7:0]  r_alu_data1;
  logic [7:0]  r_alu_data2;
  logic [2:0]  r_alu_select;
  logic        r_result_valid;
  logic [2:0]  r_result_dest;
  logic [7:0]  r_result_data;
  logic        r_illegal_op;

  logic [7:0]  w_rdata1;
  logic [7:0]  w_rdata2;
  logic [7:0]  w_data1;
  logic [7:0]  w_data2;
  logic [2:0]  w_select;
  logic        w_unused_instr_bits;

  // Only the low three bits of DEST/SRC1 are register indices.
  assign w_unused_instr_bits = ^{i_instr[C_DEST_LSB+7:C_DEST_LSB+3],
                                 i_instr[C_SRC1_LSB+7:C_SRC1_LSB+3]};

  seq_regfile u_regfile (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_raddr1 (r_src1),
    .o_rdata1 (w_rdata1),
    .i_raddr2 (r_src2[2:0]),
    .o_rdata2 (w_rdata2),
    .i_we     (r_state == ST_WB),
    .i_waddr  (r_result_dest),
    .i_wdata  (r_result_data)
  );

  always_comb begin
    w_data1  = w_rdata1;
    w_data2  = w_rdata2;
    w_select = C_SEL_ADD;
    case (r_op)
      C_OP_LOADI: begin
        w_data1  = r_src2;
        w_data2  = '0;
        w_select = C_SEL_FWD;
      end
      C_OP_MOV: begin
        w_data1  = w_rdata2;
        w_data2  = '0;
        w_select = C_SEL_FWD;
      end
      C_OP_AND: w_select = C_SEL_AND;
      C_OP_OR:  w_select = C_SEL_OR;
      C_OP_SUB: w_data2  = ~w_rdata2 + 8'd1;
      default:  w_select = C_SEL_ADD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_op           <= '0;
      r_dest         <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_alu_data1    <= '0;
      r_alu_data2    <= '0;
      r_alu_select   <= '0;
      r_result_valid <= 1'b0;
      r_result_dest  <= '0;
      r_result_data  <= '0;
      r_illegal_op   <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_illegal_op   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_instr_valid) begin
            r_op         <= i_instr[C_OP_LSB +: 8];
            r_dest       <= i_instr[C_DEST_LSB +: C_IDX_W];
            r_src1       <= i_instr[C_SRC1_LSB +: C_IDX_W];
            r_src2       <= i_instr[C_SRC2_LSB +: 8];
            // Decoded at acceptance so the pulse lands in the OPRD cycle.
            r_illegal_op <= !is_legal_op(i_instr[C_OP_LSB +: 8]);
            r_state      <= ST_OPRD;
          end
        end
        ST_OPRD: begin
          if (r_illegal_op) begin
            r_state <= ST_IDLE;
          end else begin
            r_alu_data1  <= w_data1;
            r_alu_data2  <= w_data2;
            r_alu_select <= w_select;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result_data  <= i_alu_result;
          r_result_dest  <= r_dest;
          r_result_valid <= 1'b1;
          r_state        <= ST_WB;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_STATUS_FLAGS_EN
  logic r_zero_flag;
  logic r_neg_flag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_zero_flag <= 1'b0;
      r_neg_flag  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_zero_flag <= (i_alu_result == 8'h00);
      r_neg_flag  <= i_alu_result[7];
    end
  end

  assign o_zero_flag = r_zero_flag;
  assign o_neg_flag  = r_neg_flag;
`else
  // No status flags in this build.
`endif

  assign o_instr_ready  = (r_state == ST_IDLE);
  assign o_alu_data1    = r_alu_data1;
  assign o_alu_data2    = r_alu_data2;
  assign o_alu_select   = r_alu_select;
  assign o_result_valid = r_result_valid;
  assign o_result_dest  = r_result_dest;
  assign o_result_data  = r_result_data;
  assign o_illegal_op   = r_illegal_op;

endmodule
`default_nettype wire
